// File: rtl/cover_ctrl_pkg.sv
// Shared types and constants for the oven cover supervisory controller.
package cover_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_RELIEF  = 3'd4,
        ST_FAULT   = 3'd5
    } cover_state_t;

    localparam int COVER_TIMEOUT_DEFAULT = 40;

    // Actuator drive level for a state; FAULT fails open to vent the chamber.
    function automatic logic drive_open(input cover_state_t s);
        return (s == ST_OPENING) || (s == ST_OPEN) || (s == ST_RELIEF) || (s == ST_FAULT);
    endfunction

endpackage

// File: rtl/cover_travel_timer.sv
// 8-bit saturating travel tick counter; o_expired flags the last allowed tick.
module cover_travel_timer #(
    parameter int LIMIT = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (en) begin
            if (i_clear)
                r_cnt <= 8'd0;
            else if (i_count_en && (r_cnt != 8'hFF))
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = (r_cnt == LIMIT_M1);

endmodule

// File: rtl/cover_controller.sv
// Oven cover supervisory FSM: travel timeouts, pressure relief, sticky fault.
// Define COVER_CTRL_SETTLE_EN to require end-stop flags stable for two ticks.
module cover_controller
    import cover_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = COVER_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cmd_open,
    input  logic       cmd_close,
    input  logic       clear_fault,
    input  logic       S_pressure_high,
    input  logic       S_pressure_medium,
    input  logic       S_cover_closed,
    input  logic       S_cover_fully_opened,
    output logic       X_cover,
    output logic [2:0] state,
    output logic       busy,
    output logic       fault
);

    cover_state_t r_state, w_next;
    logic         r_x_cover, r_busy, r_fault;
    logic         w_closed, w_opened, w_expired, w_traveling;

`ifdef COVER_CTRL_SETTLE_EN
    logic r_closed_d, r_opened_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_closed_d <= 1'b0;
            r_opened_d <= 1'b0;
        end else if (en) begin
            r_closed_d <= S_cover_closed;
            r_opened_d <= S_cover_fully_opened;
        end
    end

    assign w_closed = S_cover_closed & r_closed_d;
    assign w_opened = S_cover_fully_opened & r_opened_d;
`else
    assign w_closed = S_cover_closed;
    assign w_opened = S_cover_fully_opened;
`endif

    assign w_traveling = (r_state == ST_OPENING) || (r_state == ST_CLOSING);

    cover_travel_timer #(.LIMIT(TIMEOUT_TICKS)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .i_clear   (w_next != r_state),
        .i_count_en(w_traveling),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        if (r_state == ST_FAULT) begin
            if (clear_fault) w_next = ST_OPENING;
        end else if (S_pressure_high) begin
            w_next = ST_RELIEF;
        end else begin
            case (r_state)
                ST_CLOSED: begin
                    if (S_pressure_medium) w_next = ST_RELIEF;
                    else if (cmd_open)     w_next = ST_OPENING;
                end
                ST_RELIEF: begin
                    if (!S_pressure_medium) w_next = ST_OPEN;
                end
                ST_OPEN: begin
                    if (cmd_close && !cmd_open && !S_pressure_medium) w_next = ST_CLOSING;
                end
                ST_OPENING: begin
                    if (w_opened)                    w_next = ST_OPEN;
                    else if (cmd_close && !cmd_open) w_next = ST_CLOSING;
                    else if (w_expired)              w_next = ST_FAULT;
                end
                ST_CLOSING: begin
                    if (w_closed)                            w_next = ST_CLOSED;
                    else if (cmd_open || S_pressure_medium)  w_next = ST_OPENING;
                    else if (w_expired)                      w_next = ST_FAULT;
                end
                default: w_next = ST_FAULT;
            endcase
        end
    end

    // Outputs are decoded from the next state so they move with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLOSING;
            r_x_cover <= 1'b0;
            r_busy    <= 1'b1;
            r_fault   <= 1'b0;
        end else if (en) begin
            r_state   <= w_next;
            r_x_cover <= drive_open(w_next);
            r_busy    <= (w_next == ST_OPENING) || (w_next == ST_CLOSING);
            r_fault   <= (w_next == ST_FAULT);
        end
    end

    assign state   = r_state;
    assign X_cover = r_x_cover;
    assign busy    = r_busy;
    assign fault   = r_fault;

endmodule

// File: tb/tb_cover_controller.sv
// Directed scoreboard bench for cover_controller; honours COVER_CTRL_SETTLE_EN.
module tb_cover_controller;
    import cover_ctrl_pkg::*;

`ifdef COVER_CTRL_SETTLE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [2:0] st;
        logic       x;
        logic       busy;
        logic       fault;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, en, cmd_open, cmd_close, clear_fault;
    logic       p_high, p_med, s_closed, s_opened;
    logic       X_cover, busy, fault;
    logic [2:0] state;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cover_controller dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .cmd_open            (cmd_open),
        .cmd_close           (cmd_close),
        .clear_fault         (clear_fault),
        .S_pressure_high     (p_high),
        .S_pressure_medium   (p_med),
        .S_cover_closed      (s_closed),
        .S_cover_fully_opened(s_opened),
        .X_cover             (X_cover),
        .state               (state),
        .busy                (busy),
        .fault               (fault)
    );

    // Expected outputs for a state, straight from the output table.
    function automatic exp_t mk(input logic [2:0] st, input string nm);
        exp_t e;
        e.st    = st;
        e.x     = (st == 3'd1) || (st == 3'd2) || (st == 3'd4) || (st == 3'd5);
        e.busy  = (st == 3'd1) || (st == 3'd3);
        e.fault = (st == 3'd5);
        e.name  = nm;
        return e;
    endfunction

    task automatic step(input logic e_, input logic [2:0] st, input string nm);
        en = e_;
        exp_q.push_back(mk(st, nm));
        @(negedge clk);
    endtask

    task automatic tick(input logic [2:0] st, input string nm);
        step(1'b1, st, nm);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                checks++;
                if ({state, X_cover, busy, fault} !== {cur.st, cur.x, cur.busy, cur.fault}) begin
                    errors++;
                    $display("FAIL %s: got st=%0d x=%b busy=%b fault=%b, want st=%0d x=%b busy=%b fault=%b",
                             cur.name, state, X_cover, busy, fault, cur.st, cur.x, cur.busy, cur.fault);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; cmd_open = 1'b0; cmd_close = 1'b0; clear_fault = 1'b0;
        p_high = 1'b0; p_med = 1'b0; s_closed = 1'b0; s_opened = 1'b0;
        @(negedge clk);
        step(1'b0, ST_CLOSING, "reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) tick(ST_CLOSING, "t1_travel");
        s_closed = 1'b1;
        for (int i = 0; i < LAT; i++) tick(ST_CLOSING, "t1_settle");
        tick(ST_CLOSED, "t1_closed");
        tick(ST_CLOSED, "t1_hold");

        cmd_open = 1'b1; tick(ST_OPENING, "t2_open_req");
        cmd_open = 1'b0; s_closed = 1'b0;
        for (int i = 0; i < 25; i++) tick(ST_OPENING, "t2_travel");
        s_opened = 1'b1;
        for (int i = 0; i < LAT; i++) tick(ST_OPENING, "t2_settle");
        tick(ST_OPEN, "t2_open");

        cmd_close = 1'b1; tick(ST_CLOSING, "close_req");
        cmd_close = 1'b0; s_opened = 1'b0;
        for (int i = 0; i < 3; i++) tick(ST_CLOSING, "closing");
        cmd_open = 1'b1; cmd_close = 1'b1; tick(ST_OPENING, "both_cmds");
        cmd_open = 1'b0; cmd_close = 1'b0;

        // Timeout count spans an en=0 gap: any drift while frozen moves the fault tick.
        for (int i = 0; i < 10; i++) tick(ST_OPENING, "to_run_a");
        cmd_close = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, ST_OPENING, "en_freeze");
        cmd_close = 1'b0;
        for (int i = 0; i < 29; i++) tick(ST_OPENING, "to_run_b");
        tick(ST_FAULT, "timeout_40");
        p_high = 1'b1; tick(ST_FAULT, "fault_ign_press");
        p_high = 1'b0; tick(ST_FAULT, "fault_sticky");
        clear_fault = 1'b1; tick(ST_OPENING, "fault_clear");
        clear_fault = 1'b0;

        for (int i = 0; i < 39; i++) begin
            if (i >= 39 - LAT) s_opened = 1'b1;
            tick(ST_OPENING, "rerun");
        end
        s_opened = 1'b1; tick(ST_OPEN, "target_beats_timeout");

        cmd_close = 1'b1; tick(ST_CLOSING, "close_req2");
        cmd_close = 1'b0; s_opened = 1'b0; s_closed = 1'b1;
        for (int i = 0; i < LAT; i++) tick(ST_CLOSING, "close_settle");
        tick(ST_CLOSED, "closed2");

        p_med = 1'b1; tick(ST_RELIEF, "med_relief");
        s_closed = 1'b0; tick(ST_RELIEF, "relief_hold");
        p_med = 1'b0; tick(ST_OPEN, "relief_exit");
        p_med = 1'b1; cmd_close = 1'b1; tick(ST_OPEN, "close_blocked");
        p_med = 1'b0; tick(ST_CLOSING, "close_ok");
        cmd_close = 1'b0;
        p_med = 1'b1; tick(ST_OPENING, "med_reopen");
        p_med = 1'b0; tick(ST_OPENING, "opening");
        p_high = 1'b1; tick(ST_RELIEF, "high_relief");
        p_high = 1'b0; p_med = 1'b1; tick(ST_RELIEF, "relief_med");
        p_med = 1'b0; tick(ST_OPEN, "relief_exit2");

        cmd_close = 1'b1; tick(ST_CLOSING, "close_req3");
        cmd_close = 1'b0; cmd_open = 1'b1; tick(ST_OPENING, "reopen");
        cmd_open = 1'b0;
        for (int i = 0; i < 3; i++) tick(ST_OPENING, "opening3");
        rst_n = 1'b0;
        step(1'b0, ST_CLOSING, "rst_mid_travel");
        rst_n = 1'b1;

        tick(ST_CLOSING, "post_rst");
        s_closed = 1'b1;
`ifdef COVER_CTRL_SETTLE_EN
        tick(ST_CLOSING, "glitch");
        s_closed = 1'b0; tick(ST_CLOSING, "glitch_ignored");
        s_closed = 1'b1; tick(ST_CLOSING, "settle_1");
        tick(ST_CLOSED, "settle_2");
`else
        tick(ST_CLOSED, "raw_closed");
`endif
        en = 1'b0;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
